// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single ARM datapath.
// Optional retired-instruction counter is enabled by defining SEQ_RETIRE_CNT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | imem_req high, wait for imem_ready, load IR
// DECODE | latch decoder outputs, trap illegal opcodes
// EXEC   | ALU cycle, flag write, branch/ALU-only retire
// MEM    | dmem_req high until dmem_ready; stores retire here
// WB     | register write and PC update
// HALT   | sticky error stop, left only by reset
module multicycle_sequencer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        dec_memRead,
  input  logic        dec_memWrite,
  input  logic        dec_regWrite,
  input  logic        dec_setFlags,
  input  logic        dec_branch,
  input  logic        dec_valid,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_load,
  output logic        flag_we,
  output logic        reg_we,
  output logic        pc_update,
  output logic        pc_branch,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_write_q, reg_write_d;
  logic       set_flags_q, set_flags_d;
  logic       branch_q, branch_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      set_flags_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      set_flags_q <= set_flags_d;
      branch_q    <= branch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    set_flags_d = set_flags_q;
    branch_d    = branch_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    flag_we     = 1'b0;
    reg_we      = 1'b0;
    pc_update   = 1'b0;
    pc_branch   = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        mem_read_d  = dec_memRead;
        mem_write_d = dec_memWrite;
        reg_write_d = dec_regWrite;
        set_flags_d = dec_setFlags;
        branch_d    = dec_branch;
        if (!dec_valid) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        flag_we = set_flags_q;
        if (mem_read_q || mem_write_q) begin
          state_d = S_MEM;
        end else if (reg_write_q) begin
          state_d = S_WB;
        end else begin
          pc_update = 1'b1;
          pc_branch = branch_q;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        // A load/store fault (both bits set) is handled as a store.
        dmem_req = 1'b1;
        dmem_we  = mem_write_q;
        if (dmem_ready) begin
          wait_cnt_d = '0;
          if (mem_write_q) begin
            pc_update = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_update = 1'b1;
        pc_branch = branch_q;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        err    = err_q;
      end
      default: begin
        halted  = 1'b1;
        err     = 1'b1;
        err_d   = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

  assign state = state_q;

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (pc_update) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks ADDS, LDUR, STUR, B, fault,
// reset and watchdog scenarios cycle by cycle against hand-computed strobes.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, dmem_ready;
  logic        dec_memRead, dec_memWrite, dec_regWrite, dec_setFlags, dec_branch, dec_valid;
  logic        imem_req, dmem_req, dmem_we, ir_load, flag_we, reg_we;
  logic        pc_update, pc_branch, halted, err;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;

`ifdef SEQ_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Output vector order: {imem_req,dmem_req,dmem_we,ir_load,flag_we,reg_we,pc_update,pc_branch,halted,err}
  localparam logic [9:0] IREQ = 10'b10_0000_0000;
  localparam logic [9:0] DREQ = 10'b01_0000_0000;
  localparam logic [9:0] DWE  = 10'b00_1000_0000;
  localparam logic [9:0] IRLD = 10'b00_0100_0000;
  localparam logic [9:0] FLG  = 10'b00_0010_0000;
  localparam logic [9:0] RWE  = 10'b00_0001_0000;
  localparam logic [9:0] PCU  = 10'b00_0000_1000;
  localparam logic [9:0] PCB  = 10'b00_0000_0100;
  localparam logic [9:0] HLT  = 10'b00_0000_0010;
  localparam logic [9:0] ERR  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b00_0000_0000;

  multicycle_sequencer #(.WAIT_LIMIT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .dec_memRead  (dec_memRead),
    .dec_memWrite (dec_memWrite),
    .dec_regWrite (dec_regWrite),
    .dec_setFlags (dec_setFlags),
    .dec_branch   (dec_branch),
    .dec_valid    (dec_valid),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_load      (ir_load),
    .flag_we      (flag_we),
    .reg_we       (reg_we),
    .pc_update    (pc_update),
    .pc_branch    (pc_branch),
    .halted       (halted),
    .err          (err),
    .state        (state),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic rd, input logic wr,
                         input logic rw, input logic sf, input logic br);
    dec_valid    = v;
    dec_memRead  = rd;
    dec_memWrite = wr;
    dec_regWrite = rw;
    dec_setFlags = sf;
    dec_branch   = br;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_state, input logic [9:0] exp_sig);
    logic [9:0] obs;
    #1;
    obs = {imem_req, dmem_req, dmem_we, ir_load, flag_we, reg_we, pc_update, pc_branch, halted, err};
    n_vec++;
    assert (state === exp_state && obs === exp_sig) else begin
      n_err++;
      $error("FAIL %s: observed state=%0d sig=%b, expected state=%0d sig=%b",
             tag, state, obs, exp_state, exp_sig);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [31:0] n);
    logic [31:0] exp_ret;
    exp_ret = CNT_EN ? n : 32'd0;
    n_vec++;
    assert (retired === exp_ret) else begin
      n_err++;
      $error("FAIL %s: observed retired=%0d, expected retired=%0d", tag, retired, exp_ret);
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // ADDS: valid, regWrite, setFlags
    imem_ready = 1'b1;
    chk("rst_fetch", 3'd0, IREQ | IRLD);
    chk_ret("rst_retired", 0);
    tick(); set_dec(1, 0, 0, 1, 1, 0);
    chk("adds_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0);
    chk("adds_exec", 3'd2, FLG);
    tick();
    chk("adds_wb", 3'd4, RWE | PCU);
    chk_ret("adds_ret_pre", 0);
    tick();
    chk("adds_next_fetch", 3'd0, IREQ | IRLD);
    chk_ret("adds_ret", 1);

    // LDUR with dmem_ready low for three MEM cycles
    tick(); set_dec(1, 1, 0, 1, 0, 0);
    chk("ldur_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0); dmem_ready = 1'b0;
    chk("ldur_exec", 3'd2, NONE);
    tick();
    chk("ldur_mem_w0", 3'd3, DREQ);
    tick();
    chk("ldur_mem_w1", 3'd3, DREQ);
    tick();
    chk("ldur_mem_w2", 3'd3, DREQ);
    tick(); dmem_ready = 1'b1;
    chk("ldur_mem_rdy", 3'd3, DREQ);
    tick(); dmem_ready = 1'b0;
    chk("ldur_wb", 3'd4, RWE | PCU);
    tick();
    chk("ldur_next_fetch", 3'd0, IREQ | IRLD);
    chk_ret("ldur_ret", 2);

    // STUR (branch bit set must not leak into pc_branch on the store path)
    tick(); set_dec(1, 0, 1, 0, 0, 1);
    chk("stur_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0);
    chk("stur_exec", 3'd2, NONE);
    tick(); dmem_ready = 1'b1;
    chk("stur_mem", 3'd3, DREQ | DWE | PCU);
    tick(); dmem_ready = 1'b0;
    chk("stur_next_fetch", 3'd0, IREQ | IRLD);
    chk_ret("stur_ret", 3);

    // B: retires from EXEC with branch source
    tick(); set_dec(1, 0, 0, 0, 0, 1);
    chk("b_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0);
    chk("b_exec", 3'd2, PCU | PCB);
    tick();
    chk("b_next_fetch", 3'd0, IREQ | IRLD);
    chk_ret("b_ret", 4);

    // memRead+memWrite fault treated as store; dmem_ready in EXEC ignored
    tick(); set_dec(1, 1, 1, 0, 1, 0);
    chk("both_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0); dmem_ready = 1'b1;
    chk("both_exec", 3'd2, FLG);
    tick();
    chk("both_mem", 3'd3, DREQ | DWE | PCU);
    tick(); dmem_ready = 1'b0;
    chk("both_next_fetch", 3'd0, IREQ | IRLD);
    chk_ret("both_ret", 5);

    // Reset during a MEM wait
    tick(); set_dec(1, 1, 0, 1, 0, 0);
    chk("rstmem_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0);
    chk("rstmem_exec", 3'd2, NONE);
    tick();
    chk("rstmem_mem_w0", 3'd3, DREQ);
    tick(); reset = 1'b1;
    chk("rstmem_mem_w1", 3'd3, DREQ);
    tick(); reset = 1'b0; imem_ready = 1'b0;
    chk("rstmem_after", 3'd0, IREQ);
    chk_ret("rstmem_ret", 0);

    // Fetch watchdog: 16 unanswered FETCH cycles, then HALT
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      chk($sformatf("timeout_fetch_%0d", i), 3'd0, IREQ);
    end
    tick();
    chk("timeout_halt", 3'd5, HLT | ERR);
    tick(); imem_ready = 1'b1; dmem_ready = 1'b1;
    chk("halt_sticky", 3'd5, HLT | ERR);
    tick(); set_dec(1, 1, 1, 1, 1, 1);
    chk("halt_quiet", 3'd5, HLT | ERR);
    chk_ret("halt_ret", 0);
    set_dec(0, 0, 0, 0, 0, 0); imem_ready = 1'b0; dmem_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("halt_reset", 3'd0, IREQ);
    reset = 1'b0;

    // Illegal opcode in DECODE
    tick(); imem_ready = 1'b1;
    chk("illegal_fetch", 3'd0, IREQ | IRLD);
    tick(); imem_ready = 1'b0; set_dec(0, 0, 0, 1, 1, 0);
    chk("illegal_decode", 3'd1, NONE);
    tick(); set_dec(0, 0, 0, 0, 0, 0);
    chk("illegal_halt", 3'd5, HLT | ERR);
    tick();
    chk("illegal_sticky", 3'd5, HLT | ERR);
    chk_ret("illegal_ret", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
